audio_clip_sched: RTL and testbench

//   Schedules playback of up to N_CLIPS sound clips stored back-to-back in one shared sample ROM.

---
 rtl/audio_clip_sched_pkg.sv | 13 +
 rtl/audio_prio_arb.sv | 27 ++
 rtl/audio_clip_sched.sv | 143 ++++++++++++++
 tb/tb_audio_clip_sched.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/audio_clip_sched_pkg.sv
// Shared audio definitions: volume sample format, idle level and the clip scheduler states.
package audio_clip_sched_pkg;

   localparam int AUDIO_BIT_WIDTH_VOLUME = 8;
   localparam logic [AUDIO_BIT_WIDTH_VOLUME-1:0] AUDIO_INITIAL_VOLUME = 8'h80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      DRAIN = 2'd2
   } clip_state_t;

endpackage

// File: rtl/audio_prio_arb.sv
// Fixed-priority arbiter: lowest set index of the pending vector wins.
module audio_prio_arb #(
   parameter int N_CLIPS = 4,
   parameter int IDX_W   = (N_CLIPS > 1) ? $clog2(N_CLIPS) : 1
) (
   input  logic [N_CLIPS-1:0] pending,
   output logic [N_CLIPS-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      // Scan downwards so the lowest set index is the last one written
      for (int i = N_CLIPS - 1; i >= 0; i--) begin
         if (pending[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/audio_clip_sched.sv
// Arbitrates clip play requests onto one shared sample ROM port and streams the
// returned samples out as the volume stream, one per clk_audio_vol edge.
module audio_clip_sched
   import audio_clip_sched_pkg::*;
#(
   parameter int N_CLIPS = 4,
   parameter int ADDR_W  = 13,
   parameter int LEN_W   = 13,
   parameter bit PREEMPT = 1'b1,
   localparam int IDX_W  = (N_CLIPS > 1) ? $clog2(N_CLIPS) : 1
) (
   input  logic                              clk_audio_vol,
   input  logic                              reset_n,
   input  logic                              enable,
   input  logic [N_CLIPS-1:0]                req,
   input  logic [N_CLIPS*ADDR_W-1:0]         clip_base,
   input  logic [N_CLIPS*LEN_W-1:0]          clip_len,
   output logic [ADDR_W-1:0]                 rom_addr,
   output logic                              rom_rd,
   input  logic [AUDIO_BIT_WIDTH_VOLUME-1:0] rom_data,
   output logic [AUDIO_BIT_WIDTH_VOLUME-1:0] vol,
   output logic [N_CLIPS-1:0]                ack,
   output logic                              busy,
   output logic [IDX_W-1:0]                  cur_clip
);

   clip_state_t          state_q, state_d;
   logic [N_CLIPS-1:0]   pending_q;
   logic [N_CLIPS-1:0]   grant_mask;
   logic [LEN_W-1:0]     offset_q, offset_d;
   logic [ADDR_W-1:0]    base_q, base_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [N_CLIPS-1:0]   ack_d;
   logic [IDX_W-1:0]     cur_clip_d;
   logic                 issue;
   logic [ADDR_W-1:0]    issue_addr;
   logic                 do_grant;
   logic                 vld_p1;

   logic [N_CLIPS-1:0]   arb_grant;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_valid;
   logic [ADDR_W-1:0]    sel_base;
   logic [LEN_W-1:0]     sel_len;

   audio_prio_arb #(
      .N_CLIPS (N_CLIPS),
      .IDX_W   (IDX_W)
   ) u_arb (
      .pending (pending_q),
      .grant   (arb_grant),
      .idx     (arb_idx),
      .valid   (arb_valid)
   );

   assign sel_base = clip_base[int'(arb_idx)*ADDR_W +: ADDR_W];
   assign sel_len  = clip_len[int'(arb_idx)*LEN_W +: LEN_W];
   assign busy     = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      grant_mask = '0;
      ack_d      = '0;
      cur_clip_d = cur_clip;
      offset_d   = offset_q;
      base_d     = base_q;
      len_d      = len_q;
      issue      = 1'b0;
      issue_addr = rom_addr;
      do_grant   = 1'b0;

      unique case (state_q)
         IDLE, DRAIN: do_grant = arb_valid;
         PLAY:        do_grant = PREEMPT && arb_valid && (arb_idx < cur_clip);
         default:     do_grant = 1'b0;
      endcase

      if (state_q == PLAY) begin
         issue      = 1'b1;
         issue_addr = base_q + ADDR_W'(offset_q);
         offset_d   = offset_q + LEN_W'(1);
         state_d    = (offset_q == len_q - LEN_W'(1)) ? DRAIN : PLAY;
      end else if (state_q == DRAIN) begin
         state_d = IDLE;
      end

      // A grant issues offset 0 on the same edge, so a DRAIN regrant is gapless
      if (do_grant) begin
         grant_mask = arb_grant;
         ack_d      = arb_grant;
         cur_clip_d = arb_idx;
         base_d     = sel_base;
         len_d      = sel_len;
         offset_d   = LEN_W'(1);
         if (sel_len == '0) begin
            issue   = 1'b0;
            state_d = IDLE;
         end else begin
            issue      = 1'b1;
            issue_addr = sel_base;
            state_d    = (sel_len == LEN_W'(1)) ? DRAIN : PLAY;
         end
      end
   end

   // Stage p0: issue address; stage p1: ROM data valid; vol registered at end of p1
   always_ff @(posedge clk_audio_vol) begin
      if (!reset_n || !enable) begin
         state_q   <= IDLE;
         pending_q <= '0;
         rom_rd    <= 1'b0;
         ack       <= '0;
         vld_p1    <= 1'b0;
         vol       <= AUDIO_INITIAL_VOLUME;
      end else begin
         state_q   <= state_d;
         pending_q <= (pending_q & ~grant_mask) | req;
         rom_rd    <= issue;
         ack       <= ack_d;
         vld_p1    <= rom_rd;
         vol       <= vld_p1 ? rom_data : AUDIO_INITIAL_VOLUME;
      end
   end

   always_ff @(posedge clk_audio_vol) begin
      if (!reset_n) begin
         rom_addr <= '0;
         cur_clip <= '0;
      end else if (enable) begin
         rom_addr <= issue_addr;
         cur_clip <= cur_clip_d;
      end
   end

   always_ff @(posedge clk_audio_vol) begin
      if (enable) begin
         offset_q <= offset_d;
         base_q   <= base_d;
         len_q    <= len_d;
      end
   end

endmodule

// File: tb/tb_audio_clip_sched.sv
// Directed bench for audio_clip_sched: per-cycle vector table plus hand-written
// sequences for the run-to-completion and same-clip retrigger cases.
module tb_audio_clip_sched;
   import audio_clip_sched_pkg::*;

   localparam int N  = 4;
   localparam int AW = 13;
   localparam int LW = 13;
   localparam int VW = AUDIO_BIT_WIDTH_VOLUME;
   localparam int I  = int'(AUDIO_INITIAL_VOLUME);

   typedef struct {
      logic          rst_n;
      logic          en;
      logic [3:0]    req;
      logic          rd;
      logic [AW-1:0] addr;
      logic [3:0]    ack;
      logic          busy;
      logic [VW-1:0] vol;
      logic [1:0]    cur;
   } vec_t;

   vec_t tbl[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset_n, enable;
   logic [N-1:0]   req;
   logic [N*AW-1:0] clip_base;
   logic [N*LW-1:0] clip_len;

   logic [AW-1:0] addr_p, addr_n;
   logic          rd_p, rd_n, busy_p, busy_n;
   logic [VW-1:0] data_p, data_n, vol_p, vol_n;
   logic [N-1:0]  ack_p, ack_n;
   logic [1:0]    cur_p, cur_n;

   assign clip_base = {13'd300, 13'd200, 13'd100, 13'd0};
   assign clip_len  = {13'd5, 13'd0, 13'd3, 13'd4};

   audio_clip_sched #(.N_CLIPS(N), .ADDR_W(AW), .LEN_W(LW), .PREEMPT(1'b1)) dut_p (
      .clk_audio_vol (clk), .reset_n (reset_n), .enable (enable), .req (req),
      .clip_base (clip_base), .clip_len (clip_len), .rom_addr (addr_p), .rom_rd (rd_p),
      .rom_data (data_p), .vol (vol_p), .ack (ack_p), .busy (busy_p), .cur_clip (cur_p)
   );

   audio_clip_sched #(.N_CLIPS(N), .ADDR_W(AW), .LEN_W(LW), .PREEMPT(1'b0)) dut_n (
      .clk_audio_vol (clk), .reset_n (reset_n), .enable (enable), .req (req),
      .clip_base (clip_base), .clip_len (clip_len), .rom_addr (addr_n), .rom_rd (rd_n),
      .rom_data (data_n), .vol (vol_n), .ack (ack_n), .busy (busy_n), .cur_clip (cur_n)
   );

   // ROM models: one cycle latency, data = address[7:0]
   always @(posedge clk) begin
      data_p <= addr_p[7:0];
      data_n <= addr_n[7:0];
   end

   task automatic add(input logic r, input logic e, input logic [3:0] q,
                      input logic d, input int a, input logic [3:0] k,
                      input logic b, input int v, input int c);
      vec_t t;
      t.rst_n = r; t.en = e; t.req = q;
      t.rd = d; t.addr = AW'(a); t.ack = k; t.busy = b; t.vol = VW'(v); t.cur = 2'(c);
      tbl.push_back(t);
   endtask

   task automatic step(input logic r, input logic e, input logic [3:0] q);
      @(negedge clk);
      reset_n = r;
      enable  = e;
      req     = q;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   initial begin
      int exp_np[9];
      int exp_rt[6];
      reset_n = 1'b0;
      enable  = 1'b1;
      req     = '0;

      // rst en req        rd addr ack     busy vol cur
      add(0,1,4'b0000,  0,   0, 4'b0000, 0, I,  0);  // reset values
      add(1,1,4'b0010,  0,   0, 4'b0000, 0, I,  0);  // clip1 request latched
      add(1,1,4'b0000,  1, 100, 4'b0010, 1, I,  1);
      add(1,1,4'b0000,  1, 101, 4'b0000, 1, I,  1);
      add(1,1,4'b0000,  1, 102, 4'b0000, 1, 100, 1);
      add(1,1,4'b0000,  0, 102, 4'b0000, 0, 101, 1);
      add(1,1,4'b0000,  0, 102, 4'b0000, 0, 102, 1);
      add(1,1,4'b0000,  0, 102, 4'b0000, 0, I,  1);
      add(1,1,4'b1001,  0, 102, 4'b0000, 0, I,  1);  // clip0 and clip3 together
      add(1,1,4'b0000,  1,   0, 4'b0001, 1, I,  0);
      add(1,1,4'b0000,  1,   1, 4'b0000, 1, I,  0);
      add(1,1,4'b0000,  1,   2, 4'b0000, 1, 0,  0);
      add(1,1,4'b0000,  1,   3, 4'b0000, 1, 1,  0);
      add(1,1,4'b0000,  1, 300, 4'b1000, 1, 2,  3);  // gapless regrant
      add(1,1,4'b0000,  1, 301, 4'b0000, 1, 3,  3);
      add(1,1,4'b0000,  1, 302, 4'b0000, 1, 44, 3);
      add(1,1,4'b0000,  1, 303, 4'b0000, 1, 45, 3);
      add(1,1,4'b0000,  1, 304, 4'b0000, 1, 46, 3);
      add(1,1,4'b0000,  0, 304, 4'b0000, 0, 47, 3);
      add(1,1,4'b0000,  0, 304, 4'b0000, 0, 48, 3);
      add(1,1,4'b0000,  0, 304, 4'b0000, 0, I,  3);
      add(1,1,4'b1000,  0, 304, 4'b0000, 0, I,  3);  // preemption case
      add(1,1,4'b0000,  1, 300, 4'b1000, 1, I,  3);
      add(1,1,4'b0000,  1, 301, 4'b0000, 1, I,  3);
      add(1,1,4'b0001,  1, 302, 4'b0000, 1, 44, 3);
      add(1,1,4'b0000,  1,   0, 4'b0001, 1, 45, 0);
      add(1,1,4'b0000,  1,   1, 4'b0000, 1, 46, 0);
      add(1,1,4'b0000,  1,   2, 4'b0000, 1, 0,  0);
      add(1,1,4'b0000,  1,   3, 4'b0000, 1, 1,  0);
      add(1,1,4'b0000,  0,   3, 4'b0000, 0, 2,  0);
      add(1,1,4'b0000,  0,   3, 4'b0000, 0, 3,  0);
      add(1,1,4'b0000,  0,   3, 4'b0000, 0, I,  0);
      add(1,1,4'b0100,  0,   3, 4'b0000, 0, I,  0);  // zero-length clip
      add(1,1,4'b0000,  0,   3, 4'b0100, 0, I,  2);
      add(1,1,4'b0000,  0,   3, 4'b0000, 0, I,  2);
      add(1,1,4'b0010,  0,   3, 4'b0000, 0, I,  2);  // enable drop case
      add(1,1,4'b1000,  1, 100, 4'b0010, 1, I,  1);
      add(1,1,4'b0000,  1, 101, 4'b0000, 1, I,  1);
      add(1,0,4'b0001,  0, 101, 4'b0000, 0, I,  1);
      add(1,1,4'b0000,  0, 101, 4'b0000, 0, I,  1);
      add(1,1,4'b0000,  0, 101, 4'b0000, 0, I,  1);
      add(1,1,4'b0001,  0, 101, 4'b0000, 0, I,  1);  // reset mid-clip case
      add(1,1,4'b0000,  1,   0, 4'b0001, 1, I,  0);
      add(1,1,4'b0000,  1,   1, 4'b0000, 1, I,  0);
      add(0,1,4'b0010,  0,   0, 4'b0000, 0, I,  0);
      add(1,1,4'b0010,  0,   0, 4'b0000, 0, I,  0);
      add(1,1,4'b0010,  1, 100, 4'b0010, 1, I,  1);
      add(1,1,4'b0000,  1, 101, 4'b0000, 1, I,  1);
      add(1,1,4'b0000,  1, 102, 4'b0000, 1, 100, 1);
      add(1,1,4'b0000,  1, 100, 4'b0010, 1, 101, 1);
      add(1,1,4'b0000,  1, 101, 4'b0000, 1, 102, 1);
      add(1,1,4'b0000,  1, 102, 4'b0000, 1, 100, 1);
      add(1,1,4'b0000,  0, 102, 4'b0000, 0, 101, 1);
      add(1,1,4'b0000,  0, 102, 4'b0000, 0, 102, 1);
      add(1,1,4'b0000,  0, 102, 4'b0000, 0, I,  1);

      foreach (tbl[i]) begin
         step(tbl[i].rst_n, tbl[i].en, tbl[i].req);
         chk($sformatf("vec%0d {rd,addr,ack,busy,vol,cur}", i),
             64'({rd_p, addr_p, ack_p, busy_p, vol_p, cur_p}),
             64'({tbl[i].rd, tbl[i].addr, tbl[i].ack, tbl[i].busy, tbl[i].vol, tbl[i].cur}));
      end

      // Run to completion: clip3 finishes before the higher-priority clip0 starts
      exp_np = '{300, 301, 302, 303, 304, 0, 1, 2, 3};
      step(1'b0, 1'b1, 4'b0000);
      step(1'b1, 1'b1, 4'b1000);
      chk("np_idle_rd", 64'(rd_n), 64'(1'b0));
      for (int k = 0; k < 9; k++) begin
         step(1'b1, 1'b1, (k == 2) ? 4'b0001 : 4'b0000);
         chk($sformatf("np_step%0d {rd,addr,ack}", k), 64'({rd_n, addr_n, ack_n}),
             64'({1'b1, AW'(exp_np[k]), (k == 0) ? 4'b1000 : (k == 5) ? 4'b0001 : 4'b0000}));
      end
      step(1'b1, 1'b1, 4'b0000);
      chk("np_end {rd,busy}", 64'({rd_n, busy_n}), 64'(2'b00));

      // Same clip re-requested mid-play replays at the end, never restarts
      exp_rt = '{100, 101, 102, 100, 101, 102};
      step(1'b0, 1'b1, 4'b0000);
      step(1'b1, 1'b1, 4'b0010);
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b1, (k == 1) ? 4'b0010 : 4'b0000);
         chk($sformatf("rt_step%0d {rd,addr,ack}", k), 64'({rd_p, addr_p, ack_p}),
             64'({1'b1, AW'(exp_rt[k]), (k == 0 || k == 3) ? 4'b0010 : 4'b0000}));
      end
      step(1'b1, 1'b1, 4'b0000);
      chk("rt_end {rd,busy}", 64'({rd_p, busy_p}), 64'(2'b00));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
